// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard for the 32x32 register file: one busy bit per register,
// RAW/WAW grant/stall at issue, writeback clear, pending count, stall counter and wb error flag.

module regfile_scoreboard_cell (
    input  logic clk,
    input  logic reset,
    input  logic set_i,
    input  logic clr_i,
    input  logic flush_i,
    output logic busy_d_o,
    output logic busy_o
);
    logic busy_q;

    // flush beats everything; a same-cycle set beats a writeback clear
    always_comb begin
        busy_d_o = busy_q;
        if (flush_i)    busy_d_o = 1'b0;
        else if (set_i) busy_d_o = 1'b1;
        else if (clr_i) busy_d_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= 1'b0;
        else       busy_q <= busy_d_o;
    end

    assign busy_o = busy_q;
endmodule

module regfile_scoreboard #(
    parameter int NREG      = 32,
    parameter int BYPASS_WB = 0,
    parameter int CNT_W     = 16,
    localparam int IW       = $clog2(NREG),
    localparam int PW       = $clog2(NREG + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [IW-1:0]    issue_rs1,
    input  logic [IW-1:0]    issue_rs2,
    input  logic [IW-1:0]    issue_rd,
    input  logic             issue_wr,
    input  logic             wb_en,
    input  logic [IW-1:0]    wb_reg,
    input  logic             flush,
    output logic             issue_ok,
    output logic             stall,
    output logic [NREG-1:0]  busy_vec,
    output logic [PW-1:0]    pending_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             wb_err
);
    logic [NREG-1:0]  busy_q, busy_d, busy_eff;
    logic [PW-1:0]    pend_q, pend_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic             err_q, err_d;
    logic             hazard, set_en, wb_clr;

    always_comb begin
        busy_eff = busy_q;
        if (BYPASS_WB != 0 && wb_en) busy_eff[wb_reg] = 1'b0;
    end

    assign hazard   = busy_eff[issue_rs1] | busy_eff[issue_rs2] | (issue_wr & busy_eff[issue_rd]);
    assign issue_ok = issue_valid & ~hazard & ~flush;
    assign stall    = issue_valid & ~issue_ok;
    assign set_en   = issue_ok & issue_wr & (issue_rd != '0);
    assign wb_clr   = wb_en & (wb_reg != '0) & ~flush;

    // register 0 is hardwired idle; the rest get a cell each
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign busy_q[i] = 1'b0;
            assign busy_d[i] = 1'b0;
        end else begin : g_cell
            regfile_scoreboard_cell u_cell (
                .clk      (clk),
                .reset    (reset),
                .set_i    (set_en & (issue_rd == IW'(i))),
                .clr_i    (wb_clr & (wb_reg == IW'(i))),
                .flush_i  (flush),
                .busy_d_o (busy_d[i]),
                .busy_o   (busy_q[i])
            );
        end
    end

    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NREG; i++) pend_d = pend_d + PW'(busy_d[i]);
    end

    assign err_d  = err_q | (wb_clr & ~busy_q[wb_reg]);
    assign scnt_d = (stall && scnt_q != '1) ? scnt_q + 1'b1 : scnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            scnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            scnt_q <= scnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec    = busy_q;
    assign pending_cnt = pend_q;
    assign stall_cnt   = scnt_q;
    assign wb_err      = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one instance per BYPASS_WB setting, a hand-computed
// vector table, randomized traffic against a set-based reference model, and stall saturation.

module tb_regfile_scoreboard;
    typedef struct packed {
        logic       rst;
        logic       iv;
        logic [4:0] rs1, rs2, rd;
        logic       wr;
        logic       wbe;
        logic [4:0] wbr;
        logic       fl;
    } in_t;

    typedef struct packed {
        in_t         i;
        logic        ok0, ok1;
        logic [31:0] busy0;
        logic [5:0]  pcnt0;
        logic [15:0] scnt0;
        logic        err0;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, issue_valid, issue_wr, wb_en, flush;
    logic [4:0] issue_rs1, issue_rs2, issue_rd, wb_reg;
    logic [1:0] ok_w, st_w, err_w;
    logic [31:0] busy_w [2];
    logic [5:0]  pc_w   [2];
    logic [15:0] sc_w   [2];

    int npass = 0, ntot = 0;

    // reference state: which registers have a write outstanding
    bit mb [2][32];
    int ms [2];
    bit me [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        regfile_scoreboard #(.NREG(32), .BYPASS_WB(k), .CNT_W(16)) u_dut (
            .clk(clk), .reset(reset), .issue_valid(issue_valid),
            .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
            .issue_wr(issue_wr), .wb_en(wb_en), .wb_reg(wb_reg), .flush(flush),
            .issue_ok(ok_w[k]), .stall(st_w[k]), .busy_vec(busy_w[k]),
            .pending_cnt(pc_w[k]), .stall_cnt(sc_w[k]), .wb_err(err_w[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else npass++;
    endtask

    function automatic in_t mkin(bit rst, bit iv, int rs1, int rs2, int rd, bit wr,
                                 bit wbe, int wbr, bit fl);
        in_t v;
        v.rst = rst; v.iv = iv; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.wr = wr; v.wbe = wbe; v.wbr = 5'(wbr); v.fl = fl;
        return v;
    endfunction

    function automatic vec_t mkv(in_t i, bit ok0, bit ok1, logic [31:0] b, int p, int s, bit e);
        vec_t t;
        t.i = i; t.ok0 = ok0; t.ok1 = ok1; t.busy0 = b;
        t.pcnt0 = 6'(p); t.scnt0 = 16'(s); t.err0 = e;
        return t;
    endfunction

    function automatic bit m_ok(int k, in_t v);
        bit eff [32];
        if (!v.iv || v.fl) return 1'b0;
        eff = mb[k];
        if (k == 1 && v.wbe) eff[v.wbr] = 1'b0;
        return !(eff[v.rs1] || eff[v.rs2] || (v.wr && eff[v.rd]));
    endfunction

    task automatic drive(input in_t v);
        reset = v.rst; issue_valid = v.iv; issue_rs1 = v.rs1; issue_rs2 = v.rs2;
        issue_rd = v.rd; issue_wr = v.wr; wb_en = v.wbe; wb_reg = v.wbr; flush = v.fl;
    endtask

    task automatic mcheck(input in_t v);
        for (int k = 0; k < 2; k++) begin
            logic [31:0] bv;
            int cnt;
            bit ok;
            bv = '0; cnt = 0;
            for (int j = 0; j < 32; j++) begin
                bv[j] = mb[k][j];
                cnt += int'(mb[k][j]);
            end
            ok = m_ok(k, v);
            chk($sformatf("model_ok[%0d]", k),    32'(ok_w[k]), 32'(ok));
            chk($sformatf("model_stall[%0d]", k), 32'(st_w[k]), 32'(v.iv && !ok));
            chk($sformatf("model_busy[%0d]", k),  busy_w[k], bv);
            chk($sformatf("model_pcnt[%0d]", k),  32'(pc_w[k]), 32'(cnt));
            chk($sformatf("model_scnt[%0d]", k),  32'(sc_w[k]), 32'(ms[k]));
            chk($sformatf("model_err[%0d]", k),   32'(err_w[k]), 32'(me[k]));
        end
    endtask

    task automatic mupdate(input in_t v);
        for (int k = 0; k < 2; k++) begin
            bit ok;
            ok = m_ok(k, v);
            if (v.rst) begin
                for (int j = 0; j < 32; j++) mb[k][j] = 1'b0;
                ms[k] = 0; me[k] = 1'b0;
            end else begin
                if (v.iv && !ok && ms[k] < 65535) ms[k]++;
                if (v.fl) begin
                    for (int j = 0; j < 32; j++) mb[k][j] = 1'b0;
                end else begin
                    if (v.wbe && v.wbr != 0) begin
                        if (!mb[k][v.wbr]) me[k] = 1'b1;
                        mb[k][v.wbr] = 1'b0;
                    end
                    if (ok && v.wr && v.rd != 0) mb[k][v.rd] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input in_t v);
        drive(v);
        #1;
        mcheck(v);
        mupdate(v);
        tick();
    endtask

    initial begin
        vec_t tbl [22];
        in_t  idle, v;

        idle = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        //                  rst iv rs1 rs2 rd wr wbe wbr fl    ok0 ok1 busy0   p  s  e
        tbl[0]  = mkv(idle,                                  0, 0, 32'h0,   0, 0, 0);
        tbl[1]  = mkv(mkin(0, 1, 0, 0, 3, 1, 0, 0, 0),       1, 1, 32'h0,   0, 0, 0);
        tbl[2]  = mkv(mkin(0, 1, 3, 0, 0, 0, 0, 0, 0),       0, 0, 32'h8,   1, 0, 0);
        tbl[3]  = mkv(mkin(0, 1, 3, 0, 0, 0, 0, 0, 0),       0, 0, 32'h8,   1, 1, 0);
        tbl[4]  = mkv(mkin(0, 1, 3, 0, 0, 0, 1, 3, 0),       0, 1, 32'h8,   1, 2, 0);
        tbl[5]  = mkv(mkin(0, 1, 3, 0, 0, 0, 0, 0, 0),       1, 1, 32'h0,   0, 3, 0);
        tbl[6]  = mkv(mkin(0, 1, 0, 0, 4, 1, 0, 0, 0),       1, 1, 32'h0,   0, 3, 0);
        tbl[7]  = mkv(mkin(0, 1, 0, 0, 4, 1, 0, 0, 0),       0, 0, 32'h10,  1, 3, 0);
        tbl[8]  = mkv(mkin(0, 1, 0, 0, 4, 1, 0, 0, 0),       0, 0, 32'h10,  1, 4, 0);
        tbl[9]  = mkv(mkin(0, 1, 0, 0, 4, 1, 1, 4, 0),       0, 1, 32'h10,  1, 5, 0);
        tbl[10] = mkv(mkin(0, 1, 0, 0, 4, 1, 0, 0, 0),       1, 0, 32'h0,   0, 6, 0);
        tbl[11] = mkv(mkin(0, 1, 0, 0, 8, 1, 0, 0, 0),       1, 1, 32'h10,  1, 6, 0);
        tbl[12] = mkv(mkin(0, 1, 0, 0, 8, 1, 1, 8, 0),       0, 1, 32'h110, 2, 6, 0);
        tbl[13] = mkv(mkin(0, 1, 0, 0, 0, 1, 0, 0, 0),       1, 1, 32'h10,  1, 7, 0);
        tbl[14] = mkv(mkin(0, 1, 0, 0, 3, 1, 0, 0, 0),       1, 1, 32'h10,  1, 7, 0);
        tbl[15] = mkv(mkin(0, 1, 0, 0, 8, 1, 0, 0, 0),       1, 0, 32'h18,  2, 7, 0);
        tbl[16] = mkv(mkin(0, 1, 3, 0, 9, 1, 0, 0, 1),       0, 0, 32'h118, 3, 7, 0);
        tbl[17] = mkv(mkin(0, 0, 0, 0, 0, 0, 1, 5, 1),       0, 0, 32'h0,   0, 8, 0);
        tbl[18] = mkv(idle,                                  0, 0, 32'h0,   0, 8, 0);
        tbl[19] = mkv(mkin(0, 0, 0, 0, 0, 0, 1, 5, 0),       0, 0, 32'h0,   0, 8, 0);
        tbl[20] = mkv(mkin(0, 0, 0, 0, 0, 0, 1, 0, 0),       0, 0, 32'h0,   0, 8, 1);
        tbl[21] = mkv(idle,                                  0, 0, 32'h0,   0, 8, 1);

        drive(mkin(1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        tick();
        mupdate(mkin(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();

        for (int r = 0; r < 22; r++) begin
            drive(tbl[r].i);
            #1;
            chk($sformatf("tbl_ok0[%0d]", r),  32'(ok_w[0]), 32'(tbl[r].ok0));
            chk($sformatf("tbl_ok1[%0d]", r),  32'(ok_w[1]), 32'(tbl[r].ok1));
            chk($sformatf("tbl_busy[%0d]", r), busy_w[0],    tbl[r].busy0);
            chk($sformatf("tbl_pcnt[%0d]", r), 32'(pc_w[0]), 32'(tbl[r].pcnt0));
            chk($sformatf("tbl_scnt[%0d]", r), 32'(sc_w[0]), 32'(tbl[r].scnt0));
            chk($sformatf("tbl_err[%0d]", r),  32'(err_w[0]), 32'(tbl[r].err0));
            mcheck(tbl[r].i);
            mupdate(tbl[r].i);
            tick();
        end

        step(mkin(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int n = 0; n < 600; n++) begin
            v.rst = ($urandom_range(0, 99) == 0);
            v.iv  = ($urandom_range(0, 3) != 0);
            v.rs1 = 5'($urandom_range(0, 7));
            v.rs2 = 5'($urandom_range(0, 7));
            v.rd  = 5'($urandom_range(0, 7));
            v.wr  = 1'($urandom_range(0, 1));
            v.wbe = ($urandom_range(0, 2) == 0);
            v.wbr = 5'($urandom_range(0, 7));
            v.fl  = ($urandom_range(0, 29) == 0);
            step(v);
        end

        // hold a RAW stall long enough to pin the counter at its ceiling
        step(mkin(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mkin(0, 1, 0, 0, 3, 1, 0, 0, 0));
        drive(mkin(0, 1, 3, 0, 0, 0, 0, 0, 0));
        for (int n = 0; n < 65540; n++) begin
            mupdate(mkin(0, 1, 3, 0, 0, 0, 0, 0, 0));
            tick();
        end
        #1;
        mcheck(mkin(0, 1, 3, 0, 0, 0, 0, 0, 0));
        chk("sat_scnt0", 32'(sc_w[0]), 32'hFFFF);
        chk("sat_scnt1", 32'(sc_w[1]), 32'hFFFF);
        step(mkin(1, 1, 3, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rst_scnt0", 32'(sc_w[0]), 32'h0);
        chk("rst_busy0", busy_w[0], 32'h0);
        step(idle);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
